// File: rtl/gr_wb_arbiter_pkg.sv
// Shared definitions for the general-register writeback arbiter and scoreboard.
package gr_wb_arbiter_pkg;

  localparam int GR_ADDR_W = 5;
  localparam int GR_DATA_W = 32;
  localparam int GR_NREG   = 32;

  typedef enum logic [1:0] {
    WB_SRC_ALU    = 2'd0,
    WB_SRC_LOAD   = 2'd1,
    WB_SRC_MULDIV = 2'd2
  } wbSrc_e;

  localparam int WB_NREQ = int'(WB_SRC_MULDIV) + 1;

endpackage

// File: rtl/gr_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping modulo N.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_gntIdx,
  output logic             o_gntValid
);

  int w_idx;

  always_comb begin
    o_gnt      = '0;
    o_gntIdx   = '0;
    o_gntValid = 1'b0;
    w_idx      = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (!o_gntValid && i_req[w_idx]) begin
        o_gntValid   = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gntIdx     = PTR_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/gr_wb_arbiter.sv
// Merges the writeback sources onto the single gr write port and keeps a per-register
// busy scoreboard so decode can stall on RAW/WAW hazards.
module gr_wb_arbiter
  import gr_wb_arbiter_pkg::*;
#(
  parameter int NREQ   = WB_NREQ,
  parameter int ADDR_W = GR_ADDR_W,
  parameter int DATA_W = GR_DATA_W,
  parameter int NREG   = GR_NREG
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_dest,
  output logic                   iss_ready,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   gr_we,
  output logic [ADDR_W-1:0]      gr_waddr,
  output logic [DATA_W-1:0]      gr_wdata,
  input  logic [ADDR_W-1:0]      qaddr1,
  input  logic [ADDR_W-1:0]      qaddr2,
  input  logic [ADDR_W-1:0]      qaddr3,
  output logic                   qbusy1,
  output logic                   qbusy2,
  output logic                   qbusy3
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]  r_rrPtr;
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busyNext;
  logic [NREQ-1:0]   w_gnt;
  logic [PTR_W-1:0]  w_gntIdx;
  logic              w_gntValid;
  logic [ADDR_W-1:0] w_selAddr;
  logic [DATA_W-1:0] w_selData;
  logic              w_doWrite;

  rr_arbiter #(
    .N     (NREQ),
    .PTR_W (PTR_W)
  ) u_rrArbiter (
    .i_req      (req_valid),
    .i_ptr      (r_rrPtr),
    .o_gnt      (w_gnt),
    .o_gntIdx   (w_gntIdx),
    .o_gntValid (w_gntValid)
  );

  assign req_ready = w_gnt;

  always_comb begin
    w_selAddr = '0;
    w_selData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_selAddr = req_addr[i*ADDR_W +: ADDR_W];
        w_selData = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // r0 is hardwired: its grants are consumed but never reach the write port
  assign w_doWrite = w_gntValid && (w_selAddr != '0);

  assign iss_ready = (iss_dest == '0) || !r_busy[iss_dest];
  assign qbusy1    = (qaddr1 != '0) && r_busy[qaddr1];
  assign qbusy2    = (qaddr2 != '0) && r_busy[qaddr2];
  assign qbusy3    = (qaddr3 != '0) && r_busy[qaddr3];

  // Clear is applied before set so a same-edge set on the same register wins
  always_comb begin
    w_busyNext = r_busy;
    if (gr_we) begin
      w_busyNext[gr_waddr] = 1'b0;
    end
    if (iss_valid && iss_ready && (iss_dest != '0)) begin
      w_busyNext[iss_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rrPtr  <= '0;
      r_busy   <= '0;
      gr_we    <= 1'b0;
      gr_waddr <= '0;
      gr_wdata <= '0;
    end else begin
      r_busy <= w_busyNext;
      gr_we  <= w_doWrite;
      if (w_gntValid) begin
        r_rrPtr <= (w_gntIdx == PTR_W'(NREQ - 1)) ? '0 : w_gntIdx + 1'b1;
      end
      if (w_doWrite) begin
        gr_waddr <= w_selAddr;
        gr_wdata <= w_selData;
      end
    end
  end

endmodule

// File: tb/tb_gr_wb_arbiter.sv
// Directed bench for gr_wb_arbiter: a vector table for arbitration/scoreboard plus
// hand-written sequences for reset mid-write, WAW stall and same-edge set/clear.
module tb_gr_wb_arbiter;

  localparam int NREQ   = 3;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [31:0] DA = 32'hA0A0_0001;
  localparam logic [31:0] DB = 32'hB1B1_0002;
  localparam logic [31:0] DC = 32'hC2C2_0003;
  localparam logic [31:0] DX = 32'hDEAD_BEEF;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   iss_valid;
  logic [ADDR_W-1:0]      iss_dest;
  logic                   iss_ready;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   gr_we;
  logic [ADDR_W-1:0]      gr_waddr;
  logic [DATA_W-1:0]      gr_wdata;
  logic [ADDR_W-1:0]      qaddr1, qaddr2, qaddr3;
  logic                   qbusy1, qbusy2, qbusy3;

  int checks = 0;
  int errors = 0;

  gr_wb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_dest  (iss_dest),
    .iss_ready (iss_ready),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .gr_we     (gr_we),
    .gr_waddr  (gr_waddr),
    .gr_wdata  (gr_wdata),
    .qaddr1    (qaddr1),
    .qaddr2    (qaddr2),
    .qaddr3    (qaddr3),
    .qbusy1    (qbusy1),
    .qbusy2    (qbusy2),
    .qbusy3    (qbusy3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        issValid;
    logic [4:0]  issDest;
    logic [2:0]  reqValid;
    logic [14:0] reqAddr;
    logic [95:0] reqData;
    logic [4:0]  qaddr;
    logic [2:0]  expReady;
    logic        expIssReady;
    logic        expQbusy;
    logic        expWe;
    logic [4:0]  expWaddr;
    logic [31:0] expWdata;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mkVec(input logic iv, input logic [4:0] id, input logic [2:0] rv,
                                 input logic [14:0] ra, input logic [95:0] rd, input logic [4:0] q,
                                 input logic [2:0] er, input logic ei, input logic eq,
                                 input logic ew, input logic [4:0] ea, input logic [31:0] ed);
    vec_t v;
    v.issValid = iv; v.issDest = id; v.reqValid = rv; v.reqAddr = ra; v.reqData = rd;
    v.qaddr = q; v.expReady = er; v.expIssReady = ei; v.expQbusy = eq;
    v.expWe = ew; v.expWaddr = ea; v.expWdata = ed;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic setQuery(input logic [4:0] q);
    qaddr1 = q;
    qaddr2 = q;
    qaddr3 = q;
  endtask

  task automatic checkQuery(input string name, input int idx, input logic exp);
    checkOutput({name, "_qbusy1"}, idx, {31'd0, qbusy1}, {31'd0, exp});
    checkOutput({name, "_qbusy2"}, idx, {31'd0, qbusy2}, {31'd0, exp});
    checkOutput({name, "_qbusy3"}, idx, {31'd0, qbusy3}, {31'd0, exp});
  endtask

  task automatic applyStimulus(input vec_t v);
    iss_valid = v.issValid;
    iss_dest  = v.issDest;
    req_valid = v.reqValid;
    req_addr  = v.reqAddr;
    req_data  = v.reqData;
    setQuery(v.qaddr);
  endtask

  task automatic idleInputs();
    iss_valid = 1'b0;
    iss_dest  = '0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  initial begin
    logic [14:0] ra, t2a, t5a;
    logic [95:0] rd, t2d, t5d;
    ra  = {5'd12, 5'd11, 5'd10};
    rd  = {DC, DB, DA};
    t2a = {5'd12, 5'd7, 5'd10};
    t2d = {DC, DX, DA};
    t5a = {5'd12, 5'd11, 5'd0};
    t5d = {DC, DB, 32'd1};

    // Each row: inputs held for one cycle; gr_* columns are the registered outputs during that cycle
    vecs[0]  = mkVec(0, 0,  3'b000, ra,  rd,  0,  3'b000, 1, 0, 0, 0,  0);
    vecs[1]  = mkVec(0, 0,  3'b100, ra,  rd,  12, 3'b100, 1, 0, 0, 0,  0);
    vecs[2]  = mkVec(0, 0,  3'b101, ra,  rd,  12, 3'b001, 1, 0, 1, 12, DC);
    vecs[3]  = mkVec(0, 0,  3'b100, ra,  rd,  12, 3'b100, 1, 0, 1, 10, DA);
    vecs[4]  = mkVec(1, 7,  3'b000, ra,  rd,  7,  3'b000, 1, 0, 1, 12, DC);
    vecs[5]  = mkVec(0, 7,  3'b010, t2a, t2d, 7,  3'b010, 0, 1, 0, 0,  0);
    vecs[6]  = mkVec(0, 7,  3'b000, t2a, t2d, 7,  3'b000, 0, 1, 1, 7,  DX);
    vecs[7]  = mkVec(0, 7,  3'b000, ra,  rd,  7,  3'b000, 1, 0, 0, 0,  0);
    vecs[8]  = mkVec(0, 0,  3'b100, ra,  rd,  12, 3'b100, 1, 0, 0, 0,  0);
    vecs[9]  = mkVec(0, 0,  3'b111, ra,  rd,  10, 3'b001, 1, 0, 1, 12, DC);
    vecs[10] = mkVec(0, 0,  3'b111, ra,  rd,  11, 3'b010, 1, 0, 1, 10, DA);
    vecs[11] = mkVec(0, 0,  3'b111, ra,  rd,  12, 3'b100, 1, 0, 1, 11, DB);
    vecs[12] = mkVec(0, 0,  3'b111, ra,  rd,  10, 3'b001, 1, 0, 1, 12, DC);
    vecs[13] = mkVec(0, 0,  3'b111, ra,  rd,  11, 3'b010, 1, 0, 1, 10, DA);
    vecs[14] = mkVec(0, 0,  3'b111, ra,  rd,  12, 3'b100, 1, 0, 1, 11, DB);
    vecs[15] = mkVec(1, 0,  3'b001, t5a, t5d, 0,  3'b001, 1, 0, 1, 12, DC);
    vecs[16] = mkVec(0, 0,  3'b000, ra,  rd,  0,  3'b000, 1, 0, 0, 0,  0);

    reset = 1'b1;
    idleInputs();
    setQuery(5'd0);

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_we",    0, {31'd0, gr_we}, 32'd0);
    checkOutput("rst_waddr", 0, {27'd0, gr_waddr}, 32'd0);
    checkOutput("rst_wdata", 0, gr_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset arriving while a write to r5 is on the gr port
    @(negedge clk);
    iss_valid = 1'b1;
    iss_dest  = 5'd5;
    setQuery(5'd5);
    @(negedge clk);
    iss_valid = 1'b0;
    req_valid = 3'b001;
    req_addr  = {5'd0, 5'd0, 5'd5};
    req_data  = {64'd0, 32'h5555_5555};
    #1;
    checkOutput("mid_ready", 0, {29'd0, req_ready}, 32'd1);
    checkQuery("mid_pre", 0, 1'b1);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("mid_we",    0, {31'd0, gr_we}, 32'd1);
    checkOutput("mid_waddr", 0, {27'd0, gr_waddr}, 32'd5);
    checkQuery("mid_busy", 0, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_we",    0, {31'd0, gr_we}, 32'd0);
    checkOutput("mid_rst_waddr", 0, {27'd0, gr_waddr}, 32'd0);
    checkOutput("mid_rst_wdata", 0, gr_wdata, 32'd0);
    checkQuery("mid_rst", 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput("vec_ready",    i, {29'd0, req_ready}, {29'd0, vecs[i].expReady});
      checkOutput("vec_issReady", i, {31'd0, iss_ready}, {31'd0, vecs[i].expIssReady});
      checkQuery("vec", i, vecs[i].expQbusy);
      checkOutput("vec_we",       i, {31'd0, gr_we}, {31'd0, vecs[i].expWe});
      if (vecs[i].expWe) begin
        checkOutput("vec_waddr", i, {27'd0, gr_waddr}, {27'd0, vecs[i].expWaddr});
        checkOutput("vec_wdata", i, gr_wdata, vecs[i].expWdata);
      end
    end

    // WAW stall on r3: blocked until the cycle after its gr write, then re-issuable
    @(negedge clk);
    idleInputs();
    iss_valid = 1'b1;
    iss_dest  = 5'd3;
    setQuery(5'd3);
    #1;
    checkOutput("waw_first", 0, {31'd0, iss_ready}, 32'd1);
    @(negedge clk);
    iss_valid = 1'b0;
    #1;
    checkOutput("waw_stall", 0, {31'd0, iss_ready}, 32'd0);
    checkQuery("waw_busy", 0, 1'b1);
    @(negedge clk);
    req_valid = 3'b010;
    req_addr  = {5'd0, 5'd3, 5'd0};
    req_data  = {32'd0, 32'h3333_3333, 32'd0};
    #1;
    checkOutput("waw_grant", 0, {29'd0, req_ready}, 32'd2);
    checkOutput("waw_stall", 1, {31'd0, iss_ready}, 32'd0);
    @(negedge clk);
    req_valid = '0;
    #1;
    checkOutput("waw_we",    0, {31'd0, gr_we}, 32'd1);
    checkOutput("waw_waddr", 0, {27'd0, gr_waddr}, 32'd3);
    checkOutput("waw_wdata", 0, gr_wdata, 32'h3333_3333);
    checkOutput("waw_stall", 2, {31'd0, iss_ready}, 32'd0);
    checkQuery("waw_busy", 1, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("waw_release", 0, {31'd0, iss_ready}, 32'd1);
    checkQuery("waw_free", 0, 1'b0);
    iss_valid = 1'b1;
    @(negedge clk);
    iss_valid = 1'b0;
    #1;
    checkOutput("waw_reissue", 0, {31'd0, iss_ready}, 32'd0);
    checkQuery("waw_reissue", 0, 1'b1);

    // Slip write to idle r4 landing on the same edge as an issue to r4: the set must survive
    @(negedge clk);
    req_valid = 3'b010;
    req_addr  = {5'd0, 5'd4, 5'd0};
    req_data  = {32'd0, 32'h4444_4444, 32'd0};
    setQuery(5'd4);
    #1;
    checkOutput("sw_grant", 0, {29'd0, req_ready}, 32'd2);
    @(negedge clk);
    req_valid = '0;
    iss_valid = 1'b1;
    iss_dest  = 5'd4;
    #1;
    checkOutput("sw_we",       0, {31'd0, gr_we}, 32'd1);
    checkOutput("sw_waddr",    0, {27'd0, gr_waddr}, 32'd4);
    checkOutput("sw_issReady", 0, {31'd0, iss_ready}, 32'd1);
    @(negedge clk);
    iss_valid = 1'b0;
    #1;
    checkOutput("sw_we_off", 0, {31'd0, gr_we}, 32'd0);
    checkQuery("sw_setwins", 0, 1'b1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
